// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/LSU requesters, the arbiter and the memory port.
// slave is the arbiter's view; master is the surrounding environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_gnt_o;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [BE_W-1:0]   dm_be_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic              dm_gnt_o;
    logic              dm_rvalid_o;
    logic [DATA_W-1:0] dm_rdata_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [BE_W-1:0]   mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              busy_o;
    logic              err_spurious_o;

    modport slave (
        input  if_req_i, if_addr_i,
        input  dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output busy_o, err_spurious_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output dm_req_i, dm_we_i, dm_be_i, dm_addr_i, dm_wdata_i,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  busy_o, err_spurious_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, data first,
// with a starvation counter that forces fetch through after STARVE_LIMIT data wins.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clk_i,
    input logic               rst_n_i,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOCK = 2'b01,
        S_RESP = 2'b10
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             err_q, err_d;

    owner_e           sel;
    logic             req;
    logic             accept;
    logic             resp;
    logic             starved;

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

    // Selection, memory-side mux, grants, response routing and next state
    always_comb begin
        sel          = owner_q;
        req          = 1'b0;
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        err_d        = err_q;
        starved      = starve_cnt_q >= CNT_W'(STARVE_LIMIT);

        bus.mem_we_o    = 1'b0;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;

        unique case (state_q)
            S_IDLE: begin
                req = bus.if_req_i | bus.dm_req_i;
                if (bus.dm_req_i && !starved)  sel = OWN_DM;
                else if (bus.if_req_i)         sel = OWN_IF;
                else if (bus.dm_req_i)         sel = OWN_DM;
                else                           sel = OWN_IF;
            end
            S_LOCK:  req = 1'b1;
            default: req = 1'b0;
        endcase

        if (req) begin
            if (sel == OWN_DM) begin
                bus.mem_we_o    = bus.dm_we_i;
                bus.mem_be_o    = bus.dm_be_i;
                bus.mem_addr_o  = bus.dm_addr_i;
                bus.mem_wdata_o = bus.dm_wdata_i;
            end else begin
                bus.mem_be_o    = '1;
                bus.mem_addr_o  = bus.if_addr_i;
            end
        end

        accept        = req & bus.mem_gnt_i;
        bus.mem_req_o = req;
        bus.if_gnt_o  = accept & (sel == OWN_IF);
        bus.dm_gnt_o  = accept & (sel == OWN_DM);

        // Responses are only legal while waiting for one; anything else is flagged
        resp            = (state_q == S_RESP) & bus.mem_rvalid_i;
        bus.if_rvalid_o = resp & (owner_q == OWN_IF);
        bus.dm_rvalid_o = resp & (owner_q == OWN_DM);
        bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : '0;
        bus.dm_rdata_o  = bus.dm_rvalid_o ? bus.mem_rdata_i : '0;
        if (bus.mem_rvalid_i && (state_q != S_RESP)) err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    owner_d = sel;
                    state_d = bus.mem_gnt_i ? S_RESP : S_LOCK;
                end
            end
            S_LOCK:  if (bus.mem_gnt_i) state_d = S_RESP;
            S_RESP:  if (bus.mem_rvalid_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Only data wins taken over a waiting fetch count toward starvation
        if (accept) begin
            if (sel == OWN_IF)                   starve_cnt_d = '0;
            else if (bus.if_req_i && !starved)   starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end

        bus.busy_o         = (state_q != S_IDLE);
        bus.err_spurious_o = err_q;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int STARVE = 4;

    logic clk_i;
    logic rst_n_i;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req_i     = 1'b0;
        bus.if_addr_i    = '0;
        bus.dm_req_i     = 1'b0;
        bus.dm_we_i      = 1'b0;
        bus.dm_be_i      = '0;
        bus.dm_addr_i    = '0;
        bus.dm_wdata_i   = '0;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    task automatic apply_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        idle_inputs();
        repeat (2) tick();
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %0b exp 0", bus.busy_o); else pass_cnt++;
        total_cnt++; if (bus.err_spurious_o !== 1'b0) $display("FAIL reset_err: got %0b exp 0", bus.err_spurious_o); else pass_cnt++;
        total_cnt++; if (bus.mem_req_o !== 1'b0) $display("FAIL reset_mem_req: got %0b exp 0", bus.mem_req_o); else pass_cnt++;
        total_cnt++; if ({bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o} !== 4'b0)
            $display("FAIL reset_handshakes: got %b exp 0000", {bus.if_gnt_o, bus.dm_gnt_o, bus.if_rvalid_o, bus.dm_rvalid_o}); else pass_cnt++;
        total_cnt++; if ({bus.if_rdata_o, bus.dm_rdata_o} !== 64'h0)
            $display("FAIL reset_rdata: got %h/%h exp 0", bus.if_rdata_o, bus.dm_rdata_o); else pass_cnt++;
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_lone_fetch();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h100; bus.mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (bus.if_gnt_o !== 1'b1 || bus.dm_gnt_o !== 1'b0)
            $display("FAIL lone_gnt: got if=%0b dm=%0b exp if=1 dm=0", bus.if_gnt_o, bus.dm_gnt_o); else pass_cnt++;
        total_cnt++; if ({bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 1'b0, 4'hF, 32'h100, 32'h0})
            $display("FAIL lone_fields: got req=%0b we=%0b be=%h addr=%h wd=%h exp 1 0 f 00000100 0",
                     bus.mem_req_o, bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o); else pass_cnt++;
        tick();
        bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hDEADBEEF;
        #2;
        total_cnt++; if (bus.if_rvalid_o !== 1'b1 || bus.if_rdata_o !== 32'hDEADBEEF)
            $display("FAIL lone_resp: got rvalid=%0b rdata=%h exp 1 deadbeef", bus.if_rvalid_o, bus.if_rdata_o); else pass_cnt++;
        total_cnt++; if (bus.dm_rvalid_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.mem_req_o !== 1'b0)
            $display("FAIL lone_resp_side: got dm_rvalid=%0b busy=%0b mem_req=%0b exp 0 1 0", bus.dm_rvalid_o, bus.busy_o, bus.mem_req_o); else pass_cnt++;
        tick();
        bus.mem_rvalid_i = 1'b0;
        #2;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL lone_idle_busy: got %0b exp 0", bus.busy_o); else pass_cnt++;
        tick();
    endtask

    task automatic test_dm_priority();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h140;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_be_i = 4'h3; bus.dm_addr_i = 32'h2000; bus.dm_wdata_i = 32'h12345678;
        bus.mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (bus.dm_gnt_o !== 1'b1 || bus.if_gnt_o !== 1'b0)
            $display("FAIL prio_gnt: got dm=%0b if=%0b exp dm=1 if=0", bus.dm_gnt_o, bus.if_gnt_o); else pass_cnt++;
        total_cnt++; if ({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== {1'b1, 4'h3, 32'h2000, 32'h12345678})
            $display("FAIL prio_fields: got we=%0b be=%h addr=%h wd=%h exp 1 3 00002000 12345678",
                     bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o); else pass_cnt++;
        tick();
        bus.dm_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0BAD0BAD;
        #2;
        total_cnt++; if (bus.dm_rvalid_o !== 1'b1 || bus.if_rvalid_o !== 1'b0)
            $display("FAIL prio_ack: got dm_rvalid=%0b if_rvalid=%0b exp 1 0", bus.dm_rvalid_o, bus.if_rvalid_o); else pass_cnt++;
        tick();
        bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (bus.if_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'h140)
            $display("FAIL prio_fetch_next: got if_gnt=%0b addr=%h exp 1 00000140", bus.if_gnt_o, bus.mem_addr_o); else pass_cnt++;
        tick();
        bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000CAFE;
        #2;
        total_cnt++; if (bus.if_rvalid_o !== 1'b1 || bus.if_rdata_o !== 32'h0000CAFE)
            $display("FAIL prio_fetch_resp: got rvalid=%0b rdata=%h exp 1 0000cafe", bus.if_rvalid_o, bus.if_rdata_o); else pass_cnt++;
        tick();
        bus.mem_rvalid_i = 1'b0;
        tick();
    endtask

    task automatic test_lock();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h300; bus.mem_gnt_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b1; bus.dm_be_i = 4'h1;
                bus.dm_addr_i = 32'h4000; bus.dm_wdata_i = 32'h55;
            end
            bus.mem_gnt_i = (c == 3);
            #2;
            total_cnt++; if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 32'h300 || bus.mem_we_o !== 1'b0)
                $display("FAIL lock_fields c=%0d: got req=%0b addr=%h we=%0b exp 1 00000300 0", c, bus.mem_req_o, bus.mem_addr_o, bus.mem_we_o); else pass_cnt++;
            total_cnt++; if (bus.if_gnt_o !== (c == 3) || bus.dm_gnt_o !== 1'b0)
                $display("FAIL lock_gnt c=%0d: got if=%0b dm=%0b exp if=%0b dm=0", c, bus.if_gnt_o, bus.dm_gnt_o, (c == 3)); else pass_cnt++;
            tick();
        end
        bus.if_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h3;
        #2;
        total_cnt++; if (bus.if_rvalid_o !== 1'b1 || bus.dm_rvalid_o !== 1'b0)
            $display("FAIL lock_resp: got if=%0b dm=%0b exp 1 0", bus.if_rvalid_o, bus.dm_rvalid_o); else pass_cnt++;
        tick();
        bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
        #2;
        total_cnt++; if (bus.dm_gnt_o !== 1'b1 || bus.mem_addr_o !== 32'h4000)
            $display("FAIL lock_dm_after: got dm_gnt=%0b addr=%h exp 1 00004000", bus.dm_gnt_o, bus.mem_addr_o); else pass_cnt++;
        tick();
        bus.dm_req_i = 1'b0; bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1;
        #2;
        total_cnt++; if (bus.dm_rvalid_o !== 1'b1) $display("FAIL lock_dm_ack: got %0b exp 1", bus.dm_rvalid_o); else pass_cnt++;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_starvation();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h500;
        bus.dm_req_i = 1'b1; bus.dm_we_i = 1'b0; bus.dm_be_i = 4'hF; bus.dm_addr_i = 32'h6000;
        for (int i = 0; i < 10; i++) begin
            logic exp_dm;
            exp_dm = ((i % (STARVE + 1)) != STARVE);
            bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b0;
            #2;
            total_cnt++; if (bus.dm_gnt_o !== exp_dm || bus.if_gnt_o !== !exp_dm)
                $display("FAIL starve_order i=%0d: got dm=%0b if=%0b exp dm=%0b", i, bus.dm_gnt_o, bus.if_gnt_o, exp_dm); else pass_cnt++;
            tick();
            bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'(i);
            #2;
            total_cnt++; if (bus.dm_rvalid_o !== exp_dm || bus.if_rvalid_o !== !exp_dm)
                $display("FAIL starve_resp i=%0d: got dm=%0b if=%0b exp dm=%0b", i, bus.dm_rvalid_o, bus.if_rvalid_o, exp_dm); else pass_cnt++;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_spurious();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hFFFF;
        #2;
        total_cnt++; if (bus.if_rvalid_o !== 1'b0 || bus.dm_rvalid_o !== 1'b0)
            $display("FAIL spur_no_rvalid: got if=%0b dm=%0b exp 0 0", bus.if_rvalid_o, bus.dm_rvalid_o); else pass_cnt++;
        tick();
        bus.mem_rvalid_i = 1'b0;
        repeat (3) tick();
        total_cnt++; if (bus.err_spurious_o !== 1'b1) $display("FAIL spur_sticky: got %0b exp 1", bus.err_spurious_o); else pass_cnt++;
        rst_n_i = 1'b0;
        #2;
        total_cnt++; if (bus.err_spurious_o !== 1'b0) $display("FAIL spur_clear: got %0b exp 0", bus.err_spurious_o); else pass_cnt++;
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.if_req_i = 1'b1; bus.if_addr_i = 32'h700; bus.mem_gnt_i = 1'b1;
        tick();
        idle_inputs();
        rst_n_i = 1'b0;
        #2;
        total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL midrst_busy: got %0b exp 0", bus.busy_o); else pass_cnt++;
        tick();
        rst_n_i = 1'b1;
        tick();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h77;
        #2;
        total_cnt++; if (bus.if_rvalid_o !== 1'b0 || bus.dm_rvalid_o !== 1'b0 || bus.busy_o !== 1'b0)
            $display("FAIL midrst_late_resp: got if=%0b dm=%0b busy=%0b exp 0 0 0", bus.if_rvalid_o, bus.dm_rvalid_o, bus.busy_o); else pass_cnt++;
        tick();
        bus.mem_rvalid_i = 1'b0;
        #2;
        total_cnt++; if (bus.err_spurious_o !== 1'b1) $display("FAIL midrst_err: got %0b exp 1", bus.err_spurious_o); else pass_cnt++;
        tick();
    endtask

    // Model tracks the port as free, committed to a requester, or awaiting its response
    task automatic test_random();
        int          if_pend = 0, dm_pend = 0;
        int          phase = 0, own = 0, starve = 0;
        int          mem_out = 0, mem_wait = 0, sel;
        logic [31:0] if_a = '0, dm_a = '0, dm_wd = '0, rd;
        logic [3:0]  dm_b = '0;
        logic        dm_w = 1'b0, exp_req, gnt, rv;
        logic [68:0] exp_f;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (if_pend == 0 && $urandom_range(0, 2) != 0) begin if_pend = 1; if_a = $urandom; end
            if (dm_pend == 0 && $urandom_range(0, 2) != 0) begin
                dm_pend = 1; dm_a = $urandom; dm_wd = $urandom;
                dm_w = 1'($urandom_range(0, 1)); dm_b = 4'($urandom_range(1, 15));
            end
            bus.if_req_i = (if_pend != 0); bus.if_addr_i = if_a;
            bus.dm_req_i = (dm_pend != 0); bus.dm_we_i = dm_w; bus.dm_be_i = dm_b;
            bus.dm_addr_i = dm_a; bus.dm_wdata_i = dm_wd;
            rd  = $urandom;
            rv  = (mem_out != 0) && (mem_wait == 0);
            gnt = (mem_out == 0) && ($urandom_range(0, 1) == 1);
            bus.mem_gnt_i = gnt; bus.mem_rvalid_i = rv; bus.mem_rdata_i = rd;

            sel = -1;
            if (phase == 0) begin
                if (dm_pend != 0 && starve < STARVE) sel = 1;
                else if (if_pend != 0)               sel = 0;
                else if (dm_pend != 0)               sel = 1;
            end else if (phase == 1) sel = own;
            exp_req = (sel >= 0);
            exp_f = (sel == 1) ? {dm_w, dm_b, dm_a, dm_wd} : {1'b0, 4'hF, if_a, 32'h0};
            #2;
            total_cnt++; if (bus.mem_req_o !== exp_req) $display("FAIL rnd_mem_req c=%0d: got %0b exp %0b", c, bus.mem_req_o, exp_req); else pass_cnt++;
            total_cnt++; if (bus.if_gnt_o !== (exp_req && gnt && sel == 0)) $display("FAIL rnd_if_gnt c=%0d: got %0b exp %0b", c, bus.if_gnt_o, (exp_req && gnt && sel == 0)); else pass_cnt++;
            total_cnt++; if (bus.dm_gnt_o !== (exp_req && gnt && sel == 1)) $display("FAIL rnd_dm_gnt c=%0d: got %0b exp %0b", c, bus.dm_gnt_o, (exp_req && gnt && sel == 1)); else pass_cnt++;
            total_cnt++; if (bus.busy_o !== (phase != 0)) $display("FAIL rnd_busy c=%0d: got %0b exp %0b", c, bus.busy_o, (phase != 0)); else pass_cnt++;
            total_cnt++; if (bus.if_rvalid_o !== (phase == 2 && rv && own == 0)) $display("FAIL rnd_if_rvalid c=%0d: got %0b exp %0b", c, bus.if_rvalid_o, (phase == 2 && rv && own == 0)); else pass_cnt++;
            total_cnt++; if (bus.dm_rvalid_o !== (phase == 2 && rv && own == 1)) $display("FAIL rnd_dm_rvalid c=%0d: got %0b exp %0b", c, bus.dm_rvalid_o, (phase == 2 && rv && own == 1)); else pass_cnt++;
            if (exp_req) begin
                total_cnt++; if ({bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o} !== exp_f)
                    $display("FAIL rnd_fields c=%0d: got %h exp %h", c, {bus.mem_we_o, bus.mem_be_o, bus.mem_addr_o, bus.mem_wdata_o}, exp_f); else pass_cnt++;
            end
            if (phase == 2 && rv) begin
                total_cnt++; if ((own == 0 ? bus.if_rdata_o : bus.dm_rdata_o) !== rd)
                    $display("FAIL rnd_rdata c=%0d: got %h exp %h", c, (own == 0 ? bus.if_rdata_o : bus.dm_rdata_o), rd); else pass_cnt++;
            end

            if (phase == 2) begin
                if (rv) begin phase = 0; mem_out = 0; end
                else mem_wait--;
            end else if (exp_req && gnt) begin
                if (sel == 1) begin
                    if (if_pend != 0 && starve < STARVE) starve++;
                    dm_pend = 0;
                end else begin
                    starve = 0; if_pend = 0;
                end
                phase = 2; own = sel; mem_out = 1; mem_wait = $urandom_range(0, 2);
            end else if (exp_req) begin
                phase = 1; own = sel;
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        rst_n_i = 1'b0;
        idle_inputs();
        test_reset();
        test_lone_fetch();
        test_dm_priority();
        test_lock();
        test_starvation();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
